// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores draining to data memory,
// with youngest-first store-to-load forwarding and fence support.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        st_valid_i,
  output logic                        st_ready_o,
  input  logic [DATA_WIDTH-1:0]       st_addr_i,
  input  logic [DATA_WIDTH-1:0]       st_data_i,
  input  logic                        st_byte_i,
  input  logic                        ld_valid_i,
  input  logic [DATA_WIDTH-1:0]       ld_addr_i,
  input  logic                        ld_byte_i,
  output logic                        ld_hit_o,
  output logic [DATA_WIDTH-1:0]       ld_data_o,
  output logic                        ld_stall_o,
  input  logic                        drain_en_i,
  input  logic                        fence_i,
  output logic                        fence_done_o,
  output logic                        mem_we_o,
  output logic                        mem_byte_op_o,
  output logic [DATA_WIDTH-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]       mem_wd_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      byte_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  assign st_ready_o   = rst_ni && (count_q < CW'(DEPTH)) && !fence_i;
  assign fence_done_o = rst_ni && fence_i && (count_q == '0);
  assign count_o      = count_q;

  assign mem_we_o      = rst_ni && (count_q != '0) && drain_en_i;
  assign mem_addr_o    = addr_q[head_q];
  assign mem_wd_o      = data_q[head_q];
  assign mem_byte_op_o = byte_q[head_q];

  assign push = st_valid_i && st_ready_o;
  assign pop  = mem_we_o;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push && !pop: count_d = count_q + 1'b1;
      !push && pop: count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      byte_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= st_addr_i;
        data_q[tail_q] <= st_data_i;
        byte_q[tail_q] <= st_byte_i;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Walk entries youngest first; the first word-address match decides.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found      = 1'b0;
    idx        = '0;
    ld_hit_o   = 1'b0;
    ld_stall_o = 1'b0;
    ld_data_o  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = head_q + PW'(i);
      if (!found && ld_valid_i && (CW'(i) < count_q) &&
          addr_q[idx][DATA_WIDTH-1:2] == ld_addr_i[DATA_WIDTH-1:2]) begin
        if (byte_q[idx]) begin
          if (!ld_byte_i) begin
            found      = 1'b1;
            ld_stall_o = 1'b1;
          end else if (addr_q[idx][1:0] == ld_addr_i[1:0]) begin
            found     = 1'b1;
            ld_hit_o  = 1'b1;
            ld_data_o = DATA_WIDTH'(data_q[idx][BYTE_WIDTH-1:0]);
          end
        end else begin
          found    = 1'b1;
          ld_hit_o = 1'b1;
          if (ld_byte_i)
            ld_data_o = DATA_WIDTH'(data_q[idx][
              int'(ld_addr_i[1:0]) * BYTE_WIDTH +: BYTE_WIDTH]);
          else
            ld_data_o = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-based model of pending stores.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        st_valid_i, st_ready_o, st_byte_i;
  logic [31:0] st_addr_i, st_data_i;
  logic        ld_valid_i, ld_byte_i, ld_hit_o, ld_stall_o;
  logic [31:0] ld_addr_i, ld_data_o;
  logic        drain_en_i, fence_i, fence_done_o;
  logic        mem_we_o, mem_byte_op_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [2:0]  count_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        b;
  } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  store_buffer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_byte_i(st_byte_i),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_byte_i(ld_byte_i),
    .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_stall_o(ld_stall_o),
    .drain_en_i(drain_en_i), .fence_i(fence_i),
    .fence_done_o(fence_done_o),
    .mem_we_o(mem_we_o), .mem_byte_op_o(mem_byte_op_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .count_o(count_o)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(bit sv, logic [31:0] sa, logic [31:0] sd, bit sb,
                       bit lv, logic [31:0] la, bit lb, bit de, bit fe);
    st_valid_i = sv; st_addr_i = sa; st_data_i = sd; st_byte_i = sb;
    ld_valid_i = lv; ld_addr_i = la; ld_byte_i = lb;
    drain_en_i = de; fence_i = fe;
    #1;
  endtask

  // Compare every output with the model, then commit this cycle's edge.
  task automatic finish();
    bit          ready, we, hit, stall;
    logic [31:0] data;
    ready = (mq.size() < 4) && !fence_i;
    we    = (mq.size() != 0) && drain_en_i;
    hit = 0; stall = 0; data = 0;
    if (ld_valid_i) begin
      for (int j = mq.size() - 1; j >= 0; j--) begin
        if (mq[j].a[31:2] == ld_addr_i[31:2]) begin
          if (mq[j].b) begin
            if (!ld_byte_i) begin
              stall = 1;
              break;
            end else if (mq[j].a == ld_addr_i) begin
              hit = 1;
              data = {24'h0, mq[j].d[7:0]};
              break;
            end
          end else begin
            hit = 1;
            data = ld_byte_i ? ((mq[j].d >> (8 * ld_addr_i[1:0])) & 32'hff)
                             : mq[j].d;
            break;
          end
        end
      end
    end
    chk("st_ready", 32'(st_ready_o), 32'(ready));
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("mem_we", 32'(mem_we_o), 32'(we));
    chk("fence_done", 32'(fence_done_o), 32'(fence_i && mq.size() == 0));
    if (we) begin
      chk("mem_addr", mem_addr_o, mq[0].a);
      chk("mem_wd", mem_wd_o, mq[0].d);
      chk("mem_byte", 32'(mem_byte_op_o), 32'(mq[0].b));
    end
    chk("ld_hit", 32'(ld_hit_o), 32'(hit));
    chk("ld_stall", 32'(ld_stall_o), 32'(stall));
    chk("ld_data", ld_data_o, data);
    if (we) void'(mq.pop_front());
    if (st_valid_i && ready) mq.push_back('{st_addr_i, st_data_i, st_byte_i});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(bit sv, logic [31:0] sa, logic [31:0] sd, bit sb,
                      bit lv, logic [31:0] la, bit lb, bit de, bit fe);
    drive(sv, sa, sd, sb, lv, la, lb, de, fe);
    finish();
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1, 32'h10000, 32'h1, 0, 0, 0, 0, 1, 1);
    chk("rst_ready", 32'(st_ready_o), 0);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_fdone", 32'(fence_done_o), 0);
    chk("rst_hit", 32'(ld_hit_o), 0);
    chk("rst_stall", 32'(ld_stall_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Single word store drains the cycle after acceptance
    step(1, 32'h10000, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("sw_we", 32'(mem_we_o), 1);
    chk("sw_addr", mem_addr_o, 32'h10000);
    chk("sw_wd", mem_wd_o, 32'hDEADBEEF);
    finish();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Fill with drain off, then drain in order
    for (int i = 0; i < 4; i++)
      step(1, 32'h20000 + 4 * i, 32'hA0 + i, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h20010, 32'hA4, 0, 0, 0, 0, 0, 0);
    chk("full_count", 32'(count_o), 4);
    chk("full_ready", 32'(st_ready_o), 0);
    finish();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Word store forwarded to a byte load
    step(1, 32'h10004, 32'h11223344, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h10006, 1, 0, 0);
    chk("lbu_hit", 32'(ld_hit_o), 1);
    chk("lbu_data", ld_data_o, 32'h22);
    finish();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Byte store: word load stalls, matching byte load hits
    step(1, 32'h10009, 32'h555555AB, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h10008, 0, 0, 0);
    chk("lw_stall", 32'(ld_stall_o), 1);
    chk("lw_nohit", 32'(ld_hit_o), 0);
    finish();
    drive(0, 0, 0, 0, 1, 32'h10009, 1, 0, 0);
    chk("sb_hit", 32'(ld_hit_o), 1);
    chk("sb_data", ld_data_o, 32'hAB);
    finish();
    step(0, 0, 0, 0, 1, 32'h1000A, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h10008, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 32'h10008, 0, 0, 0);
    chk("lw_unstall", 32'(ld_stall_o), 0);
    finish();

    // Youngest of two word stores wins
    step(1, 32'h10000, 32'hAAAA0000, 0, 0, 0, 0, 0, 0);
    step(1, 32'h10000, 32'hBBBB1111, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h10000, 0, 0, 0);
    chk("young_data", ld_data_o, 32'hBBBB1111);
    finish();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Fence waits for two drains
    step(1, 32'h30000, 32'h1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h30004, 32'h2, 0, 0, 0, 0, 0, 0);
    step(1, 32'h30008, 32'h3, 0, 0, 0, 0, 1, 1);
    step(1, 32'h30008, 32'h3, 0, 0, 0, 0, 1, 1);
    drive(1, 32'h30008, 32'h3, 0, 0, 0, 0, 1, 1);
    chk("fence_done", 32'(fence_done_o), 1);
    chk("fence_ready", 32'(st_ready_o), 0);
    finish();

    // Asynchronous reset in the middle of draining
    step(1, 32'h40000, 32'h7, 0, 0, 0, 0, 0, 0);
    step(1, 32'h40004, 32'h8, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("pre_rst_we", 32'(mem_we_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("async_we", 32'(mem_we_o), 0);
    chk("async_count", 32'(count_o), 0);
    mq.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    step(1, 32'h50000, 32'h9, 0, 0, 0, 0, 1, 0);

    for (int n = 0; n < 400; n++) begin
      step($urandom % 2, 32'h10000 + $urandom_range(0, 15), $urandom,
           $urandom % 2, ($urandom % 4) != 0,
           32'h10000 + $urandom_range(0, 15), $urandom % 2,
           ($urandom % 4) != 0, ($urandom % 16) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, byte lane width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count, power of two, >=2.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port st_valid_i  in  1  store request from pipeline.
REQ-007 SHALL have port st_ready_o  out  1  store accepted when st_valid_i and st_ready_o at posedge.
REQ-008 SHALL have port st_addr_i  in  DATA_WIDTH  store byte address.
REQ-009 SHALL have port st_data_i  in  DATA_WIDTH  store data; byte stores use bits [BYTE_WIDTH-1:0].
REQ-010 SHALL have port st_byte_i  in  1  1 = byte store (SB), 0 = word store (SW).
REQ-011 SHALL have port ld_valid_i  in  1  load lookup request.
REQ-012 SHALL have port ld_addr_i  in  DATA_WIDTH  load byte address.
REQ-013 SHALL have port ld_byte_i  in  1  1 = LBU, 0 = LW.
REQ-014 SHALL have port ld_hit_o  out  1  ld_data_o valid, forwarded from buffer.
REQ-015 SHALL have port ld_data_o  out  DATA_WIDTH  forwarded load data.
REQ-016 SHALL have port ld_stall_o  out  1  load must wait; partial overlap.
REQ-017 SHALL have port drain_en_i  in  1  permits write to data memory this cycle.
REQ-018 SHALL have port fence_i  in  1  blocks new stores until buffer empty.
REQ-019 SHALL have port fence_done_o  out  1  fence_i high and buffer empty.
REQ-020 SHALL have ports mem_we_o (1), mem_byte_op_o (1), mem_addr_o (DATA_WIDTH), mem_wd_o (DATA_WIDTH)  out  drive data memory we/byte_op/addr/wd; memory writes on negedge.
REQ-021 SHALL have port count_o  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-022 SHALL be a circular FIFO of {addr, data, byte} entries, head/tail pointers wrapping modulo DEPTH.
REQ-023 SHALL drive st_ready_o = (count < DEPTH) and not fence_i.
REQ-024 SHALL present the head entry combinationally on mem_* with mem_we_o = (count != 0) and drain_en_i; entry popped at the posedge ending that cycle.
REQ-025 SHALL give store-to-memory latency of one cycle: accepted at posedge N, mem_we_o high during cycle N+1 at earliest; no bypass when empty.
REQ-026 SHALL allow push and pop at the same posedge; count unchanged; push when full is never accepted, even when popping.
REQ-027 SHALL pass mem_addr_o unaligned; word alignment (addr & ~3) is the memory's job; mem_wd_o carries st_data_i unmodified.
REQ-028 SHALL compare for forwarding on word address addr[DATA_WIDTH-1:2], searching youngest to oldest; the youngest overlapping entry decides.
REQ-029 SHALL, for LW with youngest overlap a word store: ld_hit_o = 1, ld_data_o = entry data.
REQ-030 SHALL, for LBU with youngest overlap a word store: ld_hit_o = 1, ld_data_o = zero-extended lane addr[1:0] of entry data.
REQ-031 SHALL, for LBU with youngest overlap a byte store at identical byte address: ld_hit_o = 1, ld_data_o = zero-extended data[7:0]; byte store at a different byte in the same word is not an overlap.
REQ-032 SHALL, for LW with any byte store in the same word: ld_stall_o = 1, ld_hit_o = 0, until the entry drains.
REQ-033 SHALL hold ld_hit_o = ld_stall_o = 0 and ld_data_o = 0 when ld_valid_i = 0 or there is no overlap.
REQ-034 SHALL exclude an entry being pushed this cycle from forwarding; include an entry being popped this cycle.
REQ-035 SHALL drive fence_done_o = fence_i and (count == 0), combinationally.

Reset
REQ-036 SHALL, on rst_ni low, asynchronously clear pointers and count; all entries discarded, mem_we_o = 0 immediately.
REQ-037 SHALL hold outputs in reset: st_ready_o = 0, mem_we_o = 0, ld_hit_o = 0, ld_stall_o = 0, fence_done_o = 0, count_o = 0; pending stores lost.
REQ-038 SHALL resume accepting stores at the first posedge after rst_ni rises.

Verification
REQ-039 SHALL test SW 0x10000 <- 0xDEADBEEF with drain_en_i = 1 -> mem_we_o = 1, mem_addr_o = 0x10000, mem_wd_o = 0xDEADBEEF in next cycle only; count_o 1 -> 0.
REQ-040 SHALL test drain_en_i = 0 with 4 SWs -> count_o = 4, st_ready_o = 0, 5th store held; raise drain_en_i -> 4 writes in FIFO order.
REQ-041 SHALL test SW 0x10004 <- 0x11223344, then LBU 0x10006 -> ld_hit_o = 1, ld_data_o = 0x00000022.
REQ-042 SHALL test SB 0x10009 <- 0xAB, then LW 0x10008 -> ld_stall_o = 1 until drained; LBU 0x10009 -> hit, data 0x000000AB.
REQ-043 SHALL test SW 0x10000 A, then SW 0x10000 B, with LW 0x10000 -> ld_data_o = B (youngest wins).
REQ-044 SHALL test fence_i with 2 entries -> st_ready_o = 0, fence_done_o = 1 two drain cycles later; rst_ni low mid-drain -> mem_we_o = 0 asynchronously, count_o = 0.
